wide_add_sequencer: RTL
=======================

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the width of one word per adder pass.
REQ-002 The block SHALL have parameter NWORDS, default 4, meaning the number of words per operand, with legal range 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit, which requests a wide addition.
REQ-006 The block SHALL have port a, input, W*NWORDS bits, operand A (word 0 = bits W-1:0).
REQ-007 The block SHALL have port b, input, W*NWORDS bits, operand B.
REQ-008 The block SHALL have port cin, input, 1 bit, carry into word 0.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse that marks the result as valid.
REQ-011 The block SHALL have port s, output, W*NWORDS bits, the registered sum.
REQ-012 The block SHALL have port cout, output, 1 bit, the registered carry out of the top word.
REQ-013 The block SHALL have port ovf, output, 1 bit, registered two's-complement overflow of the full-width add.

Function
REQ-014 The block SHALL implement states IDLE, ADD and DONE.
REQ-015 In IDLE, a rising edge with start=1 SHALL capture a, b and cin into internal registers, clear the word index to 0, and enter ADD.
REQ-016 Each ADD cycle SHALL compute one W-bit add: word[idx] of A + word[idx] of B + carry register.
REQ-017 Each ADD cycle SHALL write the W-bit result into s word idx, load the carry register with the word carry-out, and increment idx.
REQ-018 The per-word add SHALL be a combinational W-bit adder with carry-in and carry-out; the team's 32-bit prefix adder SHALL be instantiated for it when W=32.
REQ-019 ADD SHALL last exactly NWORDS cycles; after the edge that processes idx=NWORDS-1, the block SHALL enter DONE.
REQ-020 On entering DONE, cout SHALL equal the final carry, and ovf SHALL equal (A msb == B msb) && (s msb != A msb).
REQ-021 done SHALL be high for exactly one cycle, while in DONE; the next edge SHALL return to IDLE, or re-enter ADD if start=1.
REQ-022 busy SHALL be high in ADD and low in IDLE and DONE.
REQ-023 Latency SHALL be fixed: start sampled at edge k gives done high in the cycle after edge k+NWORDS.
REQ-024 start SHALL be ignored while in ADD; captured operands SHALL be unaffected by input changes after capture.
REQ-025 s, cout and ovf SHALL hold their last values from DONE until the next result overwrites them; s words SHALL update progressively during ADD.
REQ-026 idx SHALL be ceil(log2(NWORDS)) bits wide and SHALL never be used outside 0..NWORDS-1.
REQ-027 The arithmetic SHALL be unsigned modulo 2^(W*NWORDS), with cout as bit W*NWORDS.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force state IDLE, idx=0, carry register=0, busy=0, done=0, s=0, cout=0 and ovf=0.
REQ-029 Reset asserted mid-ADD SHALL abandon the operation; no done pulse SHALL follow.
REQ-030 After rst_n rises, the first start SHALL be accepted on the next clock edge.

Verification
REQ-031 The bench SHALL cover this case: A=all-ones, B=1, cin=0 (W=32, NWORDS=4) -> s=0, cout=1, ovf=0, and done exactly 5 cycles after the start edge.
REQ-032 The bench SHALL cover this case: A=0xAAAA...AA, B=0x5555...55, cin=0 -> s=all-ones, cout=0; and with cin=1 -> s=0, cout=1.
REQ-033 The bench SHALL cover this case: A=0x7FFF...FF, B=1, cin=0 -> s=0x8000...00, ovf=1, cout=0.
REQ-034 The bench SHALL cover this case: start pulsed again at ADD cycles 1-3 with different operands -> the result matches the first operands only, with a single done pulse.
REQ-035 The bench SHALL cover this case: rst_n pulled low during ADD cycle 2 -> outputs read 0 at once, no done; a new start then completes correctly.
REQ-036 The bench SHALL cover this case: start held high in the DONE cycle with new operands -> a second addition starts back-to-back and done recurs NWORDS+1 cycles later; a random self-checking loop SHALL compare against a reference (W*NWORDS+1)-bit sum.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Wide multi-word adder: one W-bit word per clock, rippling the carry
// through a register. A 32-bit prefix adder is used when W=32.

// 32-bit Kogge-Stone prefix adder with carry-in and carry-out.
module prefix_add32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_p0, w_g0;
  logic [31:0] w_p1, w_g1;
  logic [31:0] w_p2, w_g2;
  logic [31:0] w_p3, w_g3;
  logic [31:0] w_p4, w_g4;
  logic [31:0] w_g5;
  logic [31:0] w_c;

  // cin is folded into the bit-0 generate, so each group generate becomes
  // the true carry into the next bit. Low propagate bits are zeroed by the
  // shifts; those positions are already final and never read them again.
  assign w_p0 = i_a ^ i_b;
  assign w_g0 = (i_a & i_b) | {31'b0, w_p0[0] & i_cin};

  assign w_g1 = w_g0 | (w_p0 & (w_g0 << 1));
  assign w_p1 = w_p0 & (w_p0 << 1);
  assign w_g2 = w_g1 | (w_p1 & (w_g1 << 2));
  assign w_p2 = w_p1 & (w_p1 << 2);
  assign w_g3 = w_g2 | (w_p2 & (w_g2 << 4));
  assign w_p3 = w_p2 & (w_p2 << 4);
  assign w_g4 = w_g3 | (w_p3 & (w_g3 << 8));
  assign w_p4 = w_p3 & (w_p3 << 8);
  assign w_g5 = w_g4 | (w_p4 & (w_g4 << 16));

  assign w_c    = {w_g5[30:0], i_cin};
  assign o_sum  = w_p0 ^ w_c;
  assign o_cout = w_g5[31];

endmodule

module wide_add_sequencer #(
  parameter int W      = 32,
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W*NWORDS-1:0]   a,
  input  logic [W*NWORDS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [W*NWORDS-1:0]   s,
  output logic                  cout,
  output logic                  ovf
);

  localparam int              IW   = $clog2(NWORDS);
  localparam int              MSB  = W*NWORDS-1;
  localparam logic [IW-1:0]   LAST = IW'(NWORDS-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [W*NWORDS-1:0]   r_a, r_b, r_s;
  logic [IW-1:0]         r_idx;
  logic                  r_carry, r_cout, r_ovf;
  logic [W-1:0]          w_wa, w_wb, w_sum;
  logic                  w_cout;

  // Select the current word of each captured operand.
  always_comb begin
    w_wa = '0;
    w_wb = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (r_idx == IW'(i)) begin
        w_wa = r_a[i*W +: W];
        w_wb = r_b[i*W +: W];
      end
    end
  end

  if (W == 32) begin : g_pfx
    prefix_add32 u_add (
      .i_a    (w_wa),
      .i_b    (w_wb),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
    );
  end else begin : g_rca
    assign {w_cout, w_sum} = {1'b0, w_wa} + {1'b0, w_wb} + {{W{1'b0}}, r_carry};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: ADD runs for exactly NWORDS cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADD;
      S_ADD:   if (r_idx == LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_ADD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, per-word accumulation and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        S_ADD: begin
          for (int unsigned i = 0; i < NWORDS; i++) begin
            if (r_idx == IW'(i)) r_s[i*W +: W] <= w_sum;
          end
          r_carry <= w_cout;
          if (r_idx == LAST) begin
            r_cout <= w_cout;
            r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_sum[W-1] != r_a[MSB]);
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_ADD);
  assign done = (r_state == S_DONE);
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
